pc_sequencer: RTL

Fetch-stage program counter sequencer for the minicpu pipeline. Owns the PC register and drives the instruction-memory request handshake. Consumes the EX-stage branch/jump decision (`PCsel`, `PCoffset`, `PCjump`) and the register target, and redirects fetch. Tracks IF/ID/EX PCs internally, squashes wrong-path instructions, and handles exception redirection.

---
 rtl/pc_sequencer_pkg.sv | 23 ++
 rtl/pc_target.sv | 32 +++
 rtl/pc_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared vectors, PC-select codes and FSM encoding for the fetch sequencer
package pc_sequencer_pkg;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
   localparam logic [31:0] EXC_VECTOR   = 32'h8000_0080;

   // one-hot PCsel codes driven by EX
   localparam logic [4:0] SELECT_PC_INC      = 5'b00001;
   localparam logic [4:0] SELECT_PC_ADD      = 5'b00010;
   localparam logic [4:0] SELECT_PC_JUMP     = 5'b00100;
   localparam logic [4:0] SELECT_PC_REGISTER = 5'b01000;

   typedef enum logic [1:0] {
      ST_RST  = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } pcseq_state_e;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/pc_target.sv
// rtl/pc_target.sv - combinational redirect target mux/adder for the fetch sequencer
module pc_target (
   input  logic [4:0]  sel,
   input  logic        exc,
   input  logic [31:0] ex_pc,
   input  logic [31:0] offset,
   input  logic [25:0] jump_field,
   input  logic [31:0] reg_val,
   output logic [31:0] target
);
   import pc_sequencer_pkg::*;

   logic [31:0] ex_pc4;

   // exception vector overrides every PCsel choice; otherwise pick by the one-hot code
   always_comb begin
      ex_pc4 = pc_plus4(ex_pc);
      target = ex_pc4;
      if (exc) begin
         target = EXC_VECTOR;
      end else begin
         case (sel)
            SELECT_PC_INC:      target = ex_pc4;
            SELECT_PC_ADD:      target = ex_pc4 + offset;
            SELECT_PC_JUMP:     target = {ex_pc4[31:28], jump_field, 2'b00};
            SELECT_PC_REGISTER: target = reg_val;
            default:            target = ex_pc4;
         endcase
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer; PCSEQ_DELAY_SLOT_EN selects delay-slot squash behaviour
module pc_sequencer (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [4:0]  PCsel,
   input  logic        PCselValid,
   input  logic [31:0] PCoffset,
   input  logic [25:0] PCjump,
   input  logic [31:0] PCreg,
   input  logic        Exc,
   input  logic        Stall,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemAck,
   output logic        IFvalid,
   output logic [31:0] IFpc,
   output logic        SquashID,
   output logic [31:0] EPC
);
   import pc_sequencer_pkg::*;

   pcseq_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  id_pc_q, id_pc_d;
   logic [31:0]  ex_pc_q, ex_pc_d;
   logic         pend_q, pend_d;
   logic         pend_exc_q, pend_exc_d;
   logic [31:0]  pend_tgt_q, pend_tgt_d;
   logic [31:0]  epc_q, epc_d;
   logic         squash_q, squash_d;

   logic [31:0]  tgt;
   logic [31:0]  redir_tgt;
   logic         redir;
   logic         ack_in_req;
   logic         discard;
   logic         advance;
   logic         keep_exc;

   pc_target u_pc_target (
      .sel        (PCsel),
      .exc        (Exc),
      .ex_pc      (ex_pc_q),
      .offset     (PCoffset),
      .jump_field (PCjump),
      .reg_val    (PCreg),
      .target     (tgt)
   );

   // classify this cycle: redirect request, live ack, discarded ack, pipeline advance
   always_comb begin
      redir      = Exc | (PCselValid & ((PCsel == SELECT_PC_ADD) |
                                        (PCsel == SELECT_PC_JUMP) |
                                        (PCsel == SELECT_PC_REGISTER)));
      ack_in_req = (state_q == ST_REQ) & ImemAck;
      discard    = ack_in_req & (pend_q | redir);
      advance    = (ack_in_req & ~discard & ~Stall) |
                   ((state_q == ST_HOLD) & ~Stall & ~redir);
      // a pending exception redirect must not be displaced by a plain branch
      keep_exc   = pend_q & pend_exc_q & ~Exc;
      redir_tgt  = keep_exc ? pend_tgt_q : tgt;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RST:  state_d = ST_REQ;
         ST_REQ:  if (ack_in_req && !discard && Stall) state_d = ST_HOLD;
         ST_HOLD: if (redir || !Stall) state_d = ST_REQ;
         default: state_d = ST_RST;
      endcase
   end

   // PC, history, pending redirect, EPC and squash next values
   always_comb begin
      pc_d       = pc_q;
      id_pc_d    = id_pc_q;
      ex_pc_d    = ex_pc_q;
      pend_d     = pend_q;
      pend_exc_d = pend_exc_q;
      pend_tgt_d = pend_tgt_q;
      epc_d      = epc_q;

      if (redir && (state_q != ST_REQ || ack_in_req)) begin
         pc_d = redir_tgt;
      end else if (ack_in_req && pend_q) begin
         pc_d = pend_tgt_q;
      end else if (advance) begin
         pc_d = pc_plus4(pc_q);
      end

      if (advance) begin
         id_pc_d = pc_q;
         ex_pc_d = id_pc_q;
      end

      if (ack_in_req) begin
         pend_d     = 1'b0;
         pend_exc_d = 1'b0;
      end else if (redir && state_q == ST_REQ) begin
         pend_d = 1'b1;
         if (!keep_exc) begin
            pend_tgt_d = tgt;
            pend_exc_d = Exc;
         end
      end

      if (Exc) epc_d = ex_pc_q;

`ifdef PCSEQ_DELAY_SLOT_EN
      squash_d = Exc;
`else
      squash_d = redir;
`endif
   end

   // FSM state register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state_q <= ST_RST;
      else          state_q <= state_d;
   end

   // datapath registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pc_q       <= RESET_VECTOR;
         id_pc_q    <= 32'd0;
         ex_pc_q    <= 32'd0;
         pend_q     <= 1'b0;
         pend_exc_q <= 1'b0;
         pend_tgt_q <= 32'd0;
         epc_q      <= 32'd0;
         squash_q   <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         id_pc_q    <= id_pc_d;
         ex_pc_q    <= ex_pc_d;
         pend_q     <= pend_d;
         pend_exc_q <= pend_exc_d;
         pend_tgt_q <= pend_tgt_d;
         epc_q      <= epc_d;
         squash_q   <= squash_d;
      end
   end

   // FSM outputs; IFvalid follows the ack directly, masked when the data is stale
   always_comb begin
      ImemReq  = (state_q == ST_REQ);
      ImemAddr = pc_q;
      IFvalid  = ack_in_req & ~discard;
      IFpc     = (state_q == ST_RST) ? 32'd0 : pc_q;
      SquashID = squash_q;
      EPC      = epc_q;
   end

endmodule
